ifetch_ctrl: RTL and testbench
==============================

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h1c00_0000, fetch address loaded on reset.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: imem_req  out  1  fetch request valid.
REQ-005 Port: imem_addr  out  32  fetch address; always equals pc.
REQ-006 Port: imem_gnt  in  1  memory accepts request this cycle when imem_req=1.
REQ-007 Port: imem_rvalid  in  1  read data valid, earliest one cycle after grant, exactly once per grant.
REQ-008 Port: imem_rdata  in  32  instruction word.
REQ-009 Port: redirect_valid  in  1  branch/exception redirect, single-cycle pulse.
REQ-010 Port: redirect_pc  in  32  redirect target.
REQ-011 Port: stall  in  1  downstream cannot accept inst this cycle.
REQ-012 Port: inst_valid  out  1  output register holds a valid instruction.
REQ-013 Port: inst  out  32  fetched instruction.
REQ-014 Port: inst_pc  out  32  address of inst.
REQ-015 Port: pc  out  32  current fetch address register.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, DROP; at most one request outstanding.
REQ-017 out_free = !inst_valid || !stall; consumption = inst_valid && !stall.
REQ-018 imem_req SHALL be 1 only when state=REQ and out_free=1; combinational, no latency.
REQ-019 IDLE: go to REQ next cycle unconditionally; imem_req=0.
REQ-020 REQ, no redirect: imem_req && imem_gnt -> WAIT; else stay.
REQ-021 WAIT, no redirect: on imem_rvalid load inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0), go to REQ.
REQ-022 Redirect (any state except IDLE) SHALL have priority: pc<=redirect_pc with bits [1:0] forced 00, inst_valid<=0 same edge.
REQ-023 Redirect in REQ: granted same cycle -> DROP; else stay REQ (next request uses new pc).
REQ-024 Redirect in WAIT: imem_rvalid same cycle -> data discarded, go REQ; else go DROP.
REQ-025 DROP: imem_req=0; on imem_rvalid discard data, pc unchanged, go REQ; further redirect in DROP only updates pc.
REQ-026 Redirect in IDLE SHALL update pc and clear inst_valid; IDLE->REQ still taken.
REQ-027 Consumption without new data SHALL clear inst_valid; inst/inst_pc hold value while stalled.
REQ-028 Return data SHALL never overwrite an unconsumed instruction (guaranteed by REQ-018 gating).
REQ-029 imem_rvalid in IDLE or REQ is a protocol error and SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL asynchronously set state=IDLE, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0; imem_req=0 throughout reset.
REQ-031 Reset mid-WAIT/DROP SHALL abandon the outstanding request; memory is reset together with this block.

Structure
REQ-032 Shared package SHALL hold the state enum (2 bits) and RESET_PC default constant.
REQ-033 No sub-module; single FSM plus pc and output registers.

Verification
REQ-034 Reset release, gnt same cycle, rvalid 1 cycle later, rdata=0x02800000 -> inst_valid=1, inst_pc=0x1c000000, pc=0x1c000004.
REQ-035 inst_valid=1 with stall=1 for 3 cycles -> imem_req=0, inst/inst_pc stable; stall drops -> imem_req=1 that cycle.
REQ-036 Redirect to 0x1c000103 while WAIT, rvalid 2 cycles later -> state DROP, data discarded, next imem_addr=0x1c000100.
REQ-037 Redirect coincident with rvalid in WAIT -> inst_valid=0, pc=redirect target, state REQ.
REQ-038 pc=0xFFFFFFFC fetch completes -> pc=0x00000000.
REQ-039 rst_n asserted mid-WAIT -> same-cycle imem_req=0, pc=0x1c000000, inst_valid=0 without clock edge.

Source files
------------

// File: rtl/ifetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_ctrl_pkg
// Shared definitions for the instruction-fetch controller:
//   - ifetch_state_e : 2-bit fetch FSM state encoding
//   - RESET_PC_DEFAULT : default fetch address after reset
// ----------------------------------------------------------------------------
package ifetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DROP = 2'b11
  } ifetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  // Redirect targets are word-aligned by clearing the two low bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_ctrl.sv
// ----------------------------------------------------------------------------
// ifetch_ctrl
// Single-outstanding instruction fetch controller. Issues word fetches from
// the current pc, captures the returned instruction into an output register,
// and handles branch/exception redirects by discarding in-flight data.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req/imem_addr    fetch request and address (address is always pc)
//   imem_gnt              memory accepts the request this cycle
//   imem_rvalid/rdata     read return, once per grant
//   redirect_valid/pc     single-cycle redirect pulse and target
//   stall                 downstream cannot accept inst this cycle
//   inst_valid/inst/inst_pc  output instruction register
//   pc                    current fetch address register
// ----------------------------------------------------------------------------
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc
);

  ifetch_state_e state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          inst_valid_q, inst_valid_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   inst_pc_q, inst_pc_d;

  logic out_free;
  logic consume;
  logic granted;

  // A request is only raised when the output register will have room for
  // the returned word, so returning data never overwrites a held instruction.
  assign out_free  = !inst_valid_q || !stall;
  assign consume   = inst_valid_q && !stall;
  assign imem_req  = (state_q == ST_REQ) && out_free;
  assign granted   = imem_req && imem_gnt;
  assign imem_addr = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q && !consume;

    // Redirect wins over everything: new pc, flush the output register.
    if (redirect_valid) begin
      pc_d         = align_word(redirect_pc);
      inst_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        // A grant coinciding with a redirect still leaves a read in flight
        // whose data belongs to the old path.
        if (granted) state_d = redirect_valid ? ST_DROP : ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rvalid ? ST_REQ : ST_DROP;
        end else if (imem_rvalid) begin
          inst_d       = imem_rdata;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + 32'd4;
          state_d      = ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign pc         = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ifetch_ctrl
// Directed testbench for ifetch_ctrl. Inputs change 1 time unit after each
// rising edge; registered outputs are checked right after that, combinational
// outputs one further time unit later.
// ----------------------------------------------------------------------------
module tb_ifetch_ctrl;
  import ifetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ifetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .pc             (pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st();
    return {30'b0, dut.state_q};
  endfunction

  initial begin
    rst_n = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req",   {31'b0, imem_req},   32'h0);
    chk("rst_pc",    pc,                  32'h1c00_0000);
    chk("rst_iv",    {31'b0, inst_valid}, 32'h0);
    chk("rst_inst",  inst,                32'h0);
    chk("rst_ipc",   inst_pc,             32'h0);
    chk("rst_state", st(),                {30'b0, ST_IDLE});
    tick(); tick();
    chk("rst_req_clk", {31'b0, imem_req}, 32'h0);
    rst_n = 1'b1;

    // First fetch: grant immediately, data one cycle later.
    tick(); #1;
    chk("f1_req",  {31'b0, imem_req}, 32'h1);
    chk("f1_addr", imem_addr,         32'h1c00_0000);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0280_0000;
    #1 chk("f1_wait_req", {31'b0, imem_req}, 32'h0);
    tick();
    imem_rvalid = 1'b0;
    chk("f1_iv",   {31'b0, inst_valid}, 32'h1);
    chk("f1_inst", inst,                32'h0280_0000);
    chk("f1_ipc",  inst_pc,             32'h1c00_0000);
    chk("f1_pc",   pc,                  32'h1c00_0004);

    // Stall for three cycles; a stray rvalid in REQ must be ignored.
    stall = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hbad0_bad0;
    #1 chk("st_req0", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      imem_rvalid = 1'b0;
      #1;
      chk("st_req",  {31'b0, imem_req},   32'h0);
      chk("st_iv",   {31'b0, inst_valid}, 32'h1);
      chk("st_inst", inst,                32'h0280_0000);
      chk("st_ipc",  inst_pc,             32'h1c00_0000);
    end
    stall = 1'b0;
    #1;
    chk("unst_req",  {31'b0, imem_req}, 32'h1);
    chk("unst_addr", imem_addr,         32'h1c00_0004);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("cons_iv",    {31'b0, inst_valid}, 32'h0);
    chk("cons_state", st(),                {30'b0, ST_WAIT});

    // Redirect in WAIT, data returns two cycles later and is dropped.
    redirect_valid = 1'b1; redirect_pc = 32'h1c00_0103;
    tick();
    redirect_valid = 1'b0;
    chk("rw_state", st(), {30'b0, ST_DROP});
    chk("rw_pc",    pc,   32'h1c00_0100);
    #1 chk("rw_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("rw_state2", st(), {30'b0, ST_DROP});
    imem_rvalid = 1'b1; imem_rdata = 32'hdead_beef;
    tick();
    imem_rvalid = 1'b0;
    chk("rw_state3", st(),                {30'b0, ST_REQ});
    chk("rw_iv",     {31'b0, inst_valid}, 32'h0);
    chk("rw_pc2",    pc,                  32'h1c00_0100);
    #1;
    chk("rw_req2",   {31'b0, imem_req},   32'h1);
    chk("rw_addr",   imem_addr,           32'h1c00_0100);

    // Redirect coincident with rvalid in WAIT.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    redirect_valid = 1'b1; redirect_pc = 32'h2000_0008;
    tick();
    imem_rvalid = 1'b0; redirect_valid = 1'b0;
    chk("rc_iv",    {31'b0, inst_valid}, 32'h0);
    chk("rc_pc",    pc,                  32'h2000_0008);
    chk("rc_state", st(),                {30'b0, ST_REQ});

    // Redirect in REQ without grant; then pc wraps after the fetch.
    redirect_valid = 1'b1; redirect_pc = 32'hffff_ffff;
    tick();
    redirect_valid = 1'b0;
    chk("wr_pc",    pc,   32'hffff_fffc);
    chk("wr_state", st(), {30'b0, ST_REQ});
    #1 chk("wr_addr", imem_addr, 32'hffff_fffc);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'habcd_0001;
    tick();
    imem_rvalid = 1'b0;
    chk("wr_pc2",  pc,                  32'h0000_0000);
    chk("wr_ipc",  inst_pc,             32'hffff_fffc);
    chk("wr_inst", inst,                32'habcd_0001);
    chk("wr_iv",   {31'b0, inst_valid}, 32'h1);

    // Redirect in REQ with grant the same cycle -> DROP; redirect again in DROP.
    imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0041;
    tick();
    imem_gnt = 1'b0; redirect_valid = 1'b0;
    chk("rg_state", st(),                {30'b0, ST_DROP});
    chk("rg_pc",    pc,                  32'h0000_0040);
    chk("rg_iv",    {31'b0, inst_valid}, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    tick();
    redirect_valid = 1'b0;
    chk("rd_state", st(), {30'b0, ST_DROP});
    chk("rd_pc",    pc,   32'h0000_0080);
    imem_rvalid = 1'b1; imem_rdata = 32'h7777_7777;
    tick();
    imem_rvalid = 1'b0;
    chk("rd_state2", st(),                {30'b0, ST_REQ});
    chk("rd_pc2",    pc,                  32'h0000_0080);
    chk("rd_iv",     {31'b0, inst_valid}, 32'h0);

    // Fetch while downstream stalls; request is withheld until it frees up.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0055; stall = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    chk("sf_iv",   {31'b0, inst_valid}, 32'h1);
    chk("sf_inst", inst,                32'h0000_0055);
    chk("sf_pc",   pc,                  32'h0000_0084);
    #1 chk("sf_req", {31'b0, imem_req}, 32'h0);
    stall = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("sf_state", st(), {30'b0, ST_WAIT});

    // Asynchronous reset mid-WAIT, checked before the next clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req",   {31'b0, imem_req},   32'h0);
    chk("ar_pc",    pc,                  32'h1c00_0000);
    chk("ar_iv",    {31'b0, inst_valid}, 32'h0);
    chk("ar_inst",  inst,                32'h0);
    chk("ar_ipc",   inst_pc,             32'h0);
    chk("ar_state", st(),                {30'b0, ST_IDLE});
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
